// File: rtl/uart_matrix_tx_gen.sv
// uart_matrix_tx_gen: buffered ROWS x COLS cell array serialised as UART frames with parity, multi-stop, clear and abort
module uart_matrix_tx_gen #(
  parameter int W = 8,
  parameter int ROWS = 2,
  parameter int COLS = 4,
  parameter int DIV = 3,
  parameter int PAR = 0,
  parameter int STOP_BITS = 1,
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1,
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  d,
  input  logic [RW-1:0] row,
  input  logic [CW-1:0] col,
  input  logic [2:0]    action,
  output logic          tx,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [W-1:0]  t_cell
);
  localparam int SL = STOP_BITS * DIV;
  localparam int NW = $clog2(SL + 1);
  localparam int BW = $clog2(W + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [W-1:0] mem [ROWS][COLS];
  logic [W-1:0] sh;
  logic pbit;
  logic [NW-1:0] cnt;
  logic [BW-1:0] bi;
  logic [2:0] mode;
  logic [RW-1:0] cr, nr, sr;
  logic [CW-1:0] cc, nc, sc;
  logic row_ok, col_ok, bad, go, abort, bit_end, last, fin, load;
  always_comb begin
    row_ok = int'(row) < ROWS;
    col_ok = int'(col) < COLS;
    bad = (action == 3'd1 || action == 3'd2) ? !(row_ok && col_ok) :
          action == 3'd3 ? !row_ok : action == 3'd4 ? !col_ok : 1'b0;
    go = state == IDLE && action >= 3'd2 && action <= 3'd5 && !bad;
    abort = state != IDLE && action == 3'd7;
    bit_end = int'(cnt) == (state == STOP ? SL : DIV) - 1;
    last = mode == 3'd3 ? int'(cc) == COLS - 1 :
           mode == 3'd4 ? int'(cr) == ROWS - 1 :
           mode == 3'd5 ? (int'(cr) == ROWS - 1 && int'(cc) == COLS - 1) : 1'b1;
    fin = state == STOP && bit_end && !abort;
    nc = (mode == 3'd3 || mode == 3'd5) ? (int'(cc) == COLS - 1 ? '0 : cc + CW'(1)) : cc;
    nr = (mode == 3'd4 || (mode == 3'd5 && int'(cc) == COLS - 1)) ? cr + RW'(1) : cr;
    sr = go ? (action >= 3'd4 ? '0 : row) : nr;
    sc = go ? ((action == 3'd3 || action == 3'd5) ? '0 : col) : nc;
    load = go || (fin && !last);
    state_n = state;
    if (go)
      state_n = START;
    else if (abort)
      state_n = IDLE;
    else if (state != IDLE && bit_end)
      state_n = state == START ? DATA :
                state == DATA ? (int'(bi) == W - 1 ? (PAR != 0 ? PARITY : STOP) : DATA) :
                state == PARITY ? STOP : (last ? IDLE : START);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          mem[i][j] <= '0;
      sh <= '0;
      pbit <= 1'b0;
      cnt <= '0;
      bi <= '0;
      mode <= '0;
      cr <= '0;
      cc <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= fin && last;
      err <= state == IDLE && bad;
      if (state == IDLE && action == 3'd1 && !bad)
        mem[row][col] <= d;
      if (state == IDLE && action == 3'd6)
        for (int i = 0; i < ROWS; i++)
          for (int j = 0; j < COLS; j++)
            mem[i][j] <= '0;
      if (go)
        mode <= action;
      if (load) begin
        sh <= mem[sr][sc];
        pbit <= (^mem[sr][sc]) ^ (PAR == 2);
        cr <= sr;
        cc <= sc;
        cnt <= '0;
        bi <= '0;
      end else if (state != IDLE) begin
        cnt <= bit_end ? '0 : cnt + NW'(1);
        if (state == DATA && bit_end) begin
          sh <= sh >> 1;
          bi <= bi + BW'(1);
        end
      end
    end
  end
  assign tx = state == START ? 1'b0 : state == DATA ? sh[0] : state == PARITY ? pbit : 1'b1;
  assign busy = state != IDLE;
  assign t_cell = (row_ok && col_ok) ? mem[row][col] : '0;
endmodule
